carrier_acq_ctrl: RTL and testbench

- Acquisition/tracking sequencer for the carrier loop filter.
- Runs the loop in a wide-bandwidth sweep mode until lock is declared, then gear-shifts to narrow tracking gains after a settle interval.
- Returns to sweep on sustained loss of lock.
- Sits beside the carrier loop. It drives the loop's lead/lag exponents, sweep enable and accumulator clear, and consumes the loop's filter-enable strobe and lock flag.

---
 rtl/carrier_acq_ctrl_pkg.sv | 21 ++
 rtl/carrier_acq_ctrl_strobe_down_counter.sv | 26 ++
 rtl/carrier_acq_ctrl.sv | 119 +++++++++++
 tb/tb_carrier_acq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/carrier_acq_ctrl_pkg.sv
// Shared definitions for the carrier acquisition sequencer: acqState encodings
// (also used for status readback) and default counter width.
package carrier_acq_ctrl_pkg;

  typedef enum logic [1:0] {
    ACQ_IDLE   = 2'd0,
    ACQ_SWEEP  = 2'd1,
    ACQ_SETTLE = 2'd2,
    ACQ_TRACK  = 2'd3
  } acq_state_t;

  localparam int CNT_W_DEFAULT = 16;
  localparam int LOSS_W        = 16;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  // Acquisition-side gains apply while the loop is searching.
  function automatic logic useAcqGains(input acq_state_t st);
    return (st == ACQ_IDLE) || (st == ACQ_SWEEP);
  endfunction

endpackage

// File: rtl/carrier_acq_ctrl_strobe_down_counter.sv
// Loadable down counter that steps only on a strobe and sticks at zero.
import carrier_acq_ctrl_pkg::*;

module strobe_down_counter #(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             strobe,
  output logic             isZero
);

  logic [CNT_W-1:0] count;

  assign isZero = (count == '0);

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset)                 count <= '0;
    else if (load)             count <= loadVal;
    else if (strobe && !isZero) count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/carrier_acq_ctrl.sv
// Carrier loop acquisition/tracking sequencer (sweep -> settle -> track).
// Optional lock-loss statistic enabled by defining CARRIER_ACQ_STATS_EN.
import carrier_acq_ctrl_pkg::*;

module carrier_acq_ctrl #(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             loopEn,
  input  logic             carrierLock,
  input  logic [4:0]       acqLeadExp,
  input  logic [4:0]       acqLagExp,
  input  logic [4:0]       trkLeadExp,
  input  logic [4:0]       trkLagExp,
  input  logic [CNT_W-1:0] settleCount,
  input  logic [CNT_W-1:0] holdoffCount,
  output logic [4:0]       leadExp,
  output logic [4:0]       lagExp,
  output logic             sweepEnable,
  output logic             clearAccum,
  output logic [1:0]       acqState,
  output logic             trackLock,
  output logic [15:0]      lossCount
);

  acq_state_t       state, nxtState;
  logic             cntLoad, cntDec, cntZero;
  logic [CNT_W-1:0] cntLoadVal;

  assign acqState = state;

  // One counter serves both settle and holdoff: the two phases never overlap.
  strobe_down_counter #(.CNT_W(CNT_W)) uCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .strobe  (cntDec),
    .isZero  (cntZero)
  );

  always_comb begin
    nxtState   = state;
    cntLoad    = 1'b0;
    cntLoadVal = settleCount;
    cntDec     = 1'b0;
    if (!enable) begin
      nxtState = ACQ_IDLE;
    end else begin
      case (state)
        ACQ_IDLE:   nxtState = ACQ_SWEEP;
        ACQ_SWEEP:
          if (loopEn && carrierLock) begin
            nxtState   = ACQ_SETTLE;
            cntLoad    = 1'b1;
            cntLoadVal = settleCount;
          end
        ACQ_SETTLE:
          if (loopEn) begin
            if (!carrierLock) nxtState = ACQ_SWEEP;
            else if (cntZero) begin
              nxtState   = ACQ_TRACK;
              cntLoad    = 1'b1;
              cntLoadVal = holdoffCount;
            end else cntDec = 1'b1;
          end
        ACQ_TRACK:
          if (loopEn) begin
            if (carrierLock) begin
              cntLoad    = 1'b1;
              cntLoadVal = holdoffCount;
            end else if (cntZero) nxtState = ACQ_SWEEP;
            else cntDec = 1'b1;
          end
        default:    nxtState = ACQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACQ_IDLE;
      leadExp     <= '0;
      lagExp      <= '0;
      sweepEnable <= 1'b0;
      clearAccum  <= 1'b0;
      trackLock   <= 1'b0;
    end else begin
      state       <= nxtState;
      leadExp     <= useAcqGains(nxtState) ? acqLeadExp : trkLeadExp;
      lagExp      <= useAcqGains(nxtState) ? acqLagExp  : trkLagExp;
      sweepEnable <= (nxtState == ACQ_SWEEP);
      clearAccum  <= enable && (state == ACQ_IDLE);
      trackLock   <= (nxtState == ACQ_TRACK);
    end
  end

`ifdef CARRIER_ACQ_STATS_EN
  logic enablePrev, lossEvt;

  assign lossEvt = enable && (state == ACQ_TRACK) && loopEn && !carrierLock && cntZero;

  always_ff @(posedge clk) begin
    if (reset) begin
      enablePrev <= 1'b0;
      lossCount  <= '0;
    end else begin
      enablePrev <= enable;
      if (enable && !enablePrev)              lossCount <= '0;
      else if (lossEvt && lossCount != LOSS_MAX) lossCount <= lossCount + 16'd1;
    end
  end
`else
  assign lossCount = '0;
`endif

endmodule

// File: tb/tb_carrier_acq_ctrl.sv
// Scoreboard bench for carrier_acq_ctrl; honours CARRIER_ACQ_STATS_EN.
module tb_carrier_acq_ctrl;
  import carrier_acq_ctrl_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset, enable, loopEn, carrierLock;
  logic [4:0] acqLeadExp, acqLagExp, trkLeadExp, trkLagExp;
  logic [CNT_W-1:0] settleCount, holdoffCount;
  logic [4:0] leadExp, lagExp;
  logic sweepEnable, clearAccum, trackLock;
  logic [1:0] acqState;
  logic [15:0] lossCount;

  typedef struct packed {
    logic [1:0]  st;
    logic [4:0]  lead;
    logic [4:0]  lag;
    logic        sw;
    logic        clr;
    logic        tl;
    logic [15:0] loss;
  } obs_t;

  obs_t sbq[$];
  int nChk = 0, nPass = 0;
  logic [15:0] lossE = '0;

  carrier_acq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .loopEn(loopEn), .carrierLock(carrierLock),
    .acqLeadExp(acqLeadExp), .acqLagExp(acqLagExp), .trkLeadExp(trkLeadExp), .trkLagExp(trkLagExp),
    .settleCount(settleCount), .holdoffCount(holdoffCount), .leadExp(leadExp), .lagExp(lagExp),
    .sweepEnable(sweepEnable), .clearAccum(clearAccum), .acqState(acqState),
    .trackLock(trackLock), .lossCount(lossCount)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] st, input logic clr);
    obs_t o;
    o.st   = st;
    o.lead = (st < 2'd2) ? acqLeadExp : trkLeadExp;
    o.lag  = (st < 2'd2) ? acqLagExp  : trkLagExp;
    o.sw   = (st == 2'd1);
    o.clr  = clr;
    o.tl   = (st == 2'd3);
    o.loss = lossE;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{acqState, leadExp, lagExp, sweepEnable, clearAccum, trackLock, lossCount};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d lead=%0d lag=%0d sw=%b clr=%b tl=%b loss=%h",
                     o.st, o.lead, o.lag, o.sw, o.clr, o.tl, o.loss);
  endfunction

  task automatic bumpLoss();
`ifdef CARRIER_ACQ_STATS_EN
    if (lossE != 16'hffff) lossE = lossE + 16'd1;
`endif
  endtask

  task automatic drive(input logic en, input logic le, input logic lk);
    enable = en; loopEn = le; carrierLock = lk;
  endtask

  task automatic test_reset();
    obs_t ex, got;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    sbq.push_back('0);
    repeat (2) @(posedge clk);
    #1;
    ex = sbq.pop_front(); got = sample(); nChk++;
    if (got !== ex) $display("FAIL reset got %s want %s", fmt(got), fmt(ex));
    else nPass++;
    reset = 1'b0;
  endtask

  task automatic test_startup();
    logic en[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] st[4] = '{2'd0, 2'd1, 2'd1, 2'd1};
    logic clr[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    obs_t ex, got;
    for (int i = 0; i < 4; i++) begin
      drive(en[i], 1'b0, 1'b0);
      if (i == 1) lossE = '0;
      sbq.push_back(mk(st[i], clr[i]));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL startup[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  // Strobe every 4th clk: 1 entry strobe + 4 counted strobes reach TRACK.
  task automatic test_settle_to_track();
    int strobes = 0;
    logic [1:0] st;
    obs_t ex, got;
    settleCount = 16'd3; holdoffCount = 16'd2;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, (i % 4) == 3, 1'b1);
      if (loopEn) strobes++;
      st = (strobes == 0) ? 2'd1 : (strobes < 5) ? 2'd2 : 2'd3;
      sbq.push_back(mk(st, 1'b0));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL settle_track[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  // Holdoff of 2: two misses then relock holds; three misses re-sweep.
  task automatic test_holdoff();
    logic lk[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] st[6] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    obs_t ex, got;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, lk[i]);
      if (i == 5) bumpLoss();
      sbq.push_back(mk(st[i], 1'b0));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL holdoff[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  // Lock drops on the 2nd strobe in SETTLE; an unlocked non-strobe cycle is ignored.
  task automatic test_settle_drop();
    logic le[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic lk[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] st[4] = '{2'd2, 2'd2, 2'd1, 2'd1};
    obs_t ex, got;
    settleCount = 16'd10;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, le[i], lk[i]);
      sbq.push_back(mk(st[i], 1'b0));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL settle_drop[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  task automatic test_zero_counts();
    logic lk[3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] st[3] = '{2'd2, 2'd3, 2'd1};
    obs_t ex, got;
    settleCount = '0; holdoffCount = '0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, lk[i]);
      if (i == 2) bumpLoss();
      sbq.push_back(mk(st[i], 1'b0));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL zero_counts[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  // enable=0 coincides with a TRACK loss event: IDLE wins, no loss counted.
  task automatic test_enable_priority();
    logic en[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic le[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic lk[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] st[6] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
    logic clr[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    obs_t ex, got;
    for (int i = 0; i < 6; i++) begin
      drive(en[i], le[i], lk[i]);
      if (i == 4) lossE = '0;
      sbq.push_back(mk(st[i], clr[i]));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL enable_prio[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  task automatic test_saturation();
    obs_t ex, got;
`ifdef CARRIER_ACQ_STATS_EN
    localparam int LOSSES = 65536;
`else
    localparam int LOSSES = 40;
`endif
    settleCount = '0; holdoffCount = '0;
    for (int n = 0; n < LOSSES; n++) begin
      drive(1'b1, 1'b1, 1'b1); @(posedge clk);
      @(posedge clk);
      drive(1'b1, 1'b1, 1'b0); @(posedge clk);
      bumpLoss();
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, i != 2);
      if (i == 2) bumpLoss();
      sbq.push_back(mk((i == 0) ? 2'd2 : (i == 1) ? 2'd3 : 2'd1, 1'b0));
      @(posedge clk); #1;
      ex = sbq.pop_front(); got = sample(); nChk++;
      if (got !== ex) $display("FAIL saturation[%0d] got %s want %s", i, fmt(got), fmt(ex));
      else nPass++;
    end
  endtask

  initial begin
    acqLeadExp = 5'd8;  acqLagExp = 5'd16;
    trkLeadExp = 5'd12; trkLagExp = 5'd22;
    settleCount = 16'd3; holdoffCount = 16'd2;
    drive(1'b0, 1'b0, 1'b0);
    test_reset();
    test_startup();
    test_settle_to_track();
    test_holdoff();
    test_settle_drop();
    test_zero_counts();
    test_enable_priority();
    test_saturation();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
